// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-requester APB master front-end.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b10
    } state_e;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefDataW = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; combinational, the pointer lives in the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        unique case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_gnt;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_gpio_arbiter.sv
// Round-robin APB master for two request/ack ports; IDLE -> SETUP -> ACCESS.
// Optional ACCESS timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_gpio_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              gnt,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    state_e state;
    logic   last_gnt;
    logic   arb_valid;
    logic   arb_winner;
    logic   timed_out;
    logic   done;

    rr_arb2 u_rr_arb2 (
        .req      ({req1, req0}),
        .last_gnt (last_gnt),
        .valid    (arb_valid),
        .winner   (arb_winner)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] wait_cnt;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            wait_cnt <= '0;
        end else if (state == StSetup) begin
            wait_cnt <= '0;
        end else if (state == StAccess && !pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = (state == StAccess) && !pready && (wait_cnt == CntMax);
`else
    assign timed_out = 1'b0;
`endif

    assign done = (state == StAccess) && (pready || timed_out);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state    <= StIdle;
            last_gnt <= 1'b1;
            gnt      <= 1'b0;
            busy     <= 1'b0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            // Completion outputs are single-cycle pulses.
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            unique case (state)
                StIdle: begin
                    // Skip the ack cycle so the owner can drop req without a re-grant.
                    if (!(ack0 || ack1) && arb_valid) begin
                        state    <= StSetup;
                        gnt      <= arb_winner;
                        last_gnt <= arb_winner;
                        busy     <= 1'b1;
                        psel     <= 1'b1;
                        pwrite   <= arb_winner ? we1 : we0;
                        paddr    <= arb_winner ? addr1 : addr0;
                        pwdata   <= arb_winner ? wdata1 : wdata0;
                    end
                end
                StSetup: begin
                    state   <= StAccess;
                    penable <= 1'b1;
                end
                StAccess: begin
                    if (done) begin
                        state   <= StIdle;
                        busy    <= 1'b0;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        paddr   <= '0;
                        pwdata  <= '0;
                        ack0    <= ~gnt;
                        ack1    <= gnt;
                        err     <= timed_out;
                        rdata   <= (pwrite || timed_out) ? '0 : prdata;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/apb_gpio_arbiter.md
# apb_gpio_arbiter

Two-requester APB master front-end for the APB GPIO slave. It arbitrates round-robin between two simple request/acknowledge ports and sequences the winning transfer through APB IDLE → SETUP → ACCESS. It returns read data and a completion pulse to the owner. It sits between on-chip requesters (CPU-side bus adapter, DMA/test sequencer) and the GPIO slave's psel/penable/pwrite/paddr/pwdata/pready/prdata pins.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max ACCESS cycles awaiting pready (used only with the macro enabled)

Ports:
- pclk  in  1  clock; single clock domain, all logic on rising edge
- presetn  in  1  reset; synchronous and active-low
- req0 / req1  in  1  transfer request; held high until ack of that port
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  transfer address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse to owner
- rdata  out  DATA_W  read data; valid only while an ack is high
- err  out  1  transfer aborted by timeout; valid with ack
- gnt  out  1  owner of the current/last transfer (0 or 1)
- busy  out  1  high in SETUP and ACCESS
- psel, penable, pwrite  out  1  APB master controls
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pready  in  1  APB slave ready
- prdata  in  DATA_W  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - If no ack is high this cycle and any req is high, pick a winner, capture its we/addr/wdata into pwrite/paddr/pwdata, set gnt, go to SETUP.
  - If ack is high this cycle, make no grant. This guarantees a requester can drop req without being re-granted.
- Round-robin: the winner is the requester not equal to last_gnt when both request; the sole requester otherwise. last_gnt updates on each grant.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS.
- ACCESS: psel=1, penable=1. Stay until pready=1 is sampled.
- On completion:
  - Next cycle: state IDLE, psel=penable=0.
  - ack[gnt]=1 for exactly one cycle.
  - rdata = prdata captured on the pready edge for reads, 0 for writes.
  - err=0.
- pwrite/paddr/pwdata stay stable from SETUP through the end of ACCESS. After completion they return to 0.
- Both req high in IDLE: grant alternates strictly (0,1,0,1…) across transfers.
- Reset values (presetn low at an edge): state IDLE; psel, penable, pwrite, ack0, ack1, err, busy = 0; paddr, pwdata, rdata = 0; gnt=0; last_gnt=1, so requester 0 wins the first tie.
- Reset mid-transfer: abort immediately. No ack is issued. The requester re-issues after reset.

## Timing
- Edge N: IDLE samples req. N+1: SETUP. N+2: ACCESS.
- With pready high during the first ACCESS cycle: ack at N+3, state IDLE at N+3, earliest next grant at N+4.
- Each extra pready-low cycle adds one cycle of latency.
- Minimum back-to-back spacing: 4 cycles per transfer.

## Configuration
- Macro APB_ARB_TIMEOUT_EN, when defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT-1 with pready still low, next cycle: psel=penable=0, state IDLE, ack[gnt]=1, err=1, rdata=0.
  - The counter width is $clog2(TIMEOUT).
- When undefined: no counter, ACCESS waits indefinitely, err is tied 0.

## Structure
- Package apb_arb_pkg:
  - State encoding IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - Default ADDR_W/DATA_W constants.
- One sub-module, rr_arb2: a two-way round-robin picker.
  - Inputs: req[1:0], last_gnt.
  - Outputs: valid, winner.
  - Purely combinational; the pointer register lives in the top.

## Test plan
- Reset, then single write from port 0 (addr 0x04, wdata 0xA5A5_0001), pready tied 1 → psel at N+1, penable at N+2, ack0 at N+3, rdata=0, pwdata=0xA5A5_0001 during SETUP/ACCESS.
- Read from port 1 (addr 0x00), prdata=0x0000_00F0, pready held low 3 ACCESS cycles → ack1 three cycles later than the no-wait case, rdata=0x0000_00F0, gnt=1.
- req0 and req1 both held high for 4 transfers → grant order 0,1,0,1, each ack on the matching port, no IDLE re-grant during an ack cycle.
- presetn low during ACCESS → next cycle all APB outputs 0, no ack. The first tie after reset is granted to port 0.
- Macro on, TIMEOUT=16, pready stuck 0 → ack with err=1 exactly 16 ACCESS cycles after ACCESS entry, psel dropped, next request serviced normally.
- Macro off, pready stuck 0 for 100 cycles → remains in ACCESS, err=0, then pready=1 → normal ack.
